// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch-stage memory: default NOP encoding,
// the instruction-memory state enum and the word-alignment mask.
package mips_pkg;

  // sll $0,$0,0 encodes as all zeros.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Low two address bits of a word-aligned byte address.
  localparam logic [1:0] ALIGN_MASK = 2'b00;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } im_state_t;

endpackage

// File: rtl/instr_mem_sync_im_array.sv
// Instruction storage: one write port, one enabled read port with a
// registered output. A same-edge read of a word being written returns the
// old contents, because both sides sample the array before the update lands.
module im_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read port; rd_data holds while rd_en is low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instr_mem_sync.sv
// IF-stage instruction memory with registered one-cycle reads, stall/flush
// control, a runtime program-load port and a reset-time zero-fill.
// The RAM output register carries the fetched word; a small registered
// select decides whether that word or NOP_WORD is presented on out, so a
// stall simply freezes both the RAM read and the select.
module instr_mem_sync
  import mips_pkg::*;
#(
  parameter int                DEPTH    = 1024,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [31:0]       read_address,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              fault_misaligned,
  output logic              fault_range,
  output logic              ready,
  input  logic              load_en,
  input  logic [31:0]       load_address,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_error
);

  localparam int AW = $clog2(DEPTH);

  im_state_t         state, state_next;
  logic [AW-1:0]     fill_cnt, fill_cnt_next;
  logic              in_run;
  logic              fetch_mis, fetch_rng;
  logic              load_mis, load_rng, load_ok;
  logic              rd_en, wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              show_ram;

  assign in_run = (state == RUN);
  assign ready  = in_run;

  // Fault decode: range uses the whole word address, not just the index bits.
  assign fetch_mis = (read_address[1:0] != ALIGN_MASK);
  assign fetch_rng = ((read_address >> 2) >= 32'(DEPTH));
  assign load_mis  = (load_address[1:0] != ALIGN_MASK);
  assign load_rng  = ((load_address >> 2) >= 32'(DEPTH));
  assign load_ok   = in_run && load_en && !load_mis && !load_rng;

  // Only a clean, unsquashed, unstalled fetch updates the RAM output register.
  assign rd_en = in_run && fetch_valid && !flush && !stall && !fetch_mis && !fetch_rng;

  // During INIT the write port belongs to the zero-fill.
  assign wr_en   = !in_run || load_ok;
  assign wr_addr = in_run ? load_address[AW+1:2] : fill_cnt;
  assign wr_data = in_run ? load_data : NOP_WORD;

  im_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (read_address[AW+1:2]),
    .rd_data (rd_data)
  );

  // State and fill-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      fill_cnt <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_cnt_next;
    end
  end

  // Next state: sweep every word once, then run until the next reset.
  always_comb begin
    state_next    = state;
    fill_cnt_next = fill_cnt;
    case (state)
      INIT: begin
        fill_cnt_next = fill_cnt + AW'(1);
        if (fill_cnt == AW'(DEPTH - 1)) begin
          state_next    = RUN;
          fill_cnt_next = '0;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next    = INIT;
        fill_cnt_next = '0;
      end
    endcase
  end

  // Output control register: flush beats stall beats fetch beats idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      show_ram         <= 1'b0;
      out_valid        <= 1'b0;
      fault_misaligned <= 1'b0;
      fault_range      <= 1'b0;
      load_error       <= 1'b0;
    end else begin
      load_error <= load_en && (!in_run || load_mis || load_rng);
      if (!in_run || flush) begin
        show_ram         <= 1'b0;
        out_valid        <= 1'b0;
        fault_misaligned <= 1'b0;
        fault_range      <= 1'b0;
      end else if (stall) begin
        show_ram         <= show_ram;
        out_valid        <= out_valid;
        fault_misaligned <= fault_misaligned;
        fault_range      <= fault_range;
      end else if (fetch_valid) begin
        show_ram         <= !fetch_mis && !fetch_rng;
        out_valid        <= 1'b1;
        fault_misaligned <= fetch_mis;
        fault_range      <= fetch_rng;
      end else begin
        show_ram         <= 1'b0;
        out_valid        <= 1'b0;
        fault_misaligned <= 1'b0;
        fault_range      <= 1'b0;
      end
    end
  end

  assign out = show_ram ? rd_data : NOP_WORD;

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised successor to the combinational instruction memory. Depth, width and NOP word are generic.
- Read is synchronous and registered (one cycle), with fetch handshake, stall/flush control and a runtime program-load write port.
- A reset-time zero-fill state machine clears the array, and fault flags mark misaligned or out-of-range fetches.
- Sits in the IF stage and feeds the IF/ID register; the test harness writes programs through the load port instead of initial blocks.

Parameters:
- DEPTH, 1024, number of instruction words (power of two).
- DATA_W, 32, instruction width in bits.
- NOP_WORD, 32'h00000000, word emitted on fault or flush and written during zero-fill (sll $0,$0,0).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_valid  in  1  IF requests a read this cycle.
- read_address  in  32  byte address (PC).
- stall  in  1  hold current output (hazard unit).
- flush  in  1  squash output (branch taken).
- out  out  DATA_W  registered instruction.
- out_valid  out  1  out holds a real fetch result.
- fault_misaligned  out  1  registered; read_address[1:0]!=0 on captured fetch.
- fault_range  out  1  registered; (read_address>>2) >= DEPTH on captured fetch.
- ready  out  1  zero-fill finished; memory usable.
- load_en  in  1  write request.
- load_address  in  32  byte address for write.
- load_data  in  DATA_W  word to write.
- load_error  out  1  one-cycle pulse; last write dropped.

Behaviour:
- Reset (async, any time, including mid-fill or mid-fetch): state=INIT, fill counter=0, out=NOP_WORD, out_valid=0, both faults=0, ready=0, load_error=0. Array contents are not reset directly; the fill overwrites them.
- INIT state:
  - Each cycle writes NOP_WORD to IM[counter], then counter+1.
  - After writing IM[DEPTH-1], go to RUN; ready=1 from the next edge, so INIT lasts exactly DEPTH cycles.
  - fetch_valid, stall and flush are ignored; outputs stay at reset values.
  - load_en in INIT is dropped and pulses load_error.
- RUN, output register priority (highest first):
  1. flush: out=NOP_WORD, out_valid=0, faults=0.
  2. stall: all outputs hold.
  3. fetch_valid: out_valid=1; out=IM[read_address>>2] if no fault, else NOP_WORD; each fault flag set to its own condition (both may be 1).
  4. idle: out=NOP_WORD, out_valid=0, faults=0.
- Read latency is exactly 1 cycle. Index is read_address[log2(DEPTH)+1:2]; the range check uses full read_address>>2.
- Write, in RUN with load_en=1:
  - Aligned and in range: IM[load_address>>2]=load_data at the edge.
  - Otherwise: no write, load_error=1 for one cycle.
  - Writes proceed regardless of stall or flush.
- Same-cycle read and write to the same word: the read returns old data (read-before-write); the new data is visible to a fetch issued the following cycle.
- load_error deasserts the cycle after the pulse unless a new bad write arrives.

Decomposition:
- Shared package mips_pkg: NOP_WORD constant, IM state enum {INIT, RUN}, and an ALIGN_MASK constant (2'b00).
- One sub-module is natural: im_array, a single-port-write, single-read synchronous RAM (DEPTH x DATA_W, read-before-write).
- The FSM, fault logic and output register stay in the top module.

Test Plan:
- Reset, then count cycles -> ready rises exactly DEPTH (1024) cycles after reset release; fetch of 0x0 in RUN returns 32'h00000000 with out_valid=1.
- Load IM[0..4]=02128020, 02129022, 02729820, 0272a022, 0292a020, then fetch 0x0,0x4,...,0x10 back-to-back -> out matches each word one cycle after its request, out_valid held 1.
- Fetch 0x6 -> out=0, out_valid=1, fault_misaligned=1. Fetch 0x1000 (DEPTH=1024) -> fault_range=1. Fetch 0x1002 -> both flags=1.
- Stall held 3 cycles after fetch of 0x4 -> out stays 02129022. Assert flush with stall -> next cycle out=0, out_valid=0.
- Write 0xDEADBEEF to 0x8 while fetching 0x8 same cycle -> out=02729820; refetch next cycle -> 0xDEADBEEF. load_address=0x9 -> load_error single pulse, IM[2] unchanged.
- Assert reset at fill counter=500 -> all outputs zero immediately (asynchronous); fill restarts from 0; ready rises 1024 cycles after release.
